// File: rtl/avg_ctrl_s_axil.sv
// AXI4-Lite control/status register block for the averaging core.
// Optional interrupt registers (GIE/IER/ISR) are compiled in with `define AVG_CTRL_IRQ_EN.
module avg_ctrl_s_axil #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  ap_start,
  input  logic                  ap_done,
  input  logic                  ap_idle,
  input  logic                  ap_ready,
  output logic [DATA_W-1:0]     buf_addr,
  output logic [DATA_W-1:0]     result_addr,
  output logic [DATA_W-1:0]     num_avgs,
  output logic                  write_en,
  input  logic [DATA_W-1:0]     avg_count,
  output logic                  interrupt
);

  localparam int unsigned StrbW = DATA_W / 8;

  localparam logic [ADDR_W-1:0] AddrCtrl = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] AddrBuf  = ADDR_W'('h10);
  localparam logic [ADDR_W-1:0] AddrRes  = ADDR_W'('h1C);
  localparam logic [ADDR_W-1:0] AddrNum  = ADDR_W'('h28);
  localparam logic [ADDR_W-1:0] AddrWen  = ADDR_W'('h30);
  localparam logic [ADDR_W-1:0] AddrCnt  = ADDR_W'('h38);

  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
  typedef enum logic       {RdIdle, RdData} rd_state_e;

  wr_state_e          wr_state_q;
  logic               awready_q, wready_q, bvalid_q;
  logic [ADDR_W-1:0]  waddr_q;

  rd_state_e          rd_state_q;
  logic               arready_q, rvalid_q;
  logic [DATA_W-1:0]  rdata_q, rd_mux;

  logic [DATA_W-1:0]  buf_q, res_q, num_q, wmask, wmerge_buf, wmerge_res, wmerge_num;
  logic               wen_q, start_q, auto_restart_q, done_q, ready_q;

  logic w_hs, ar_hs, wr_ctrl, rd_ctrl;

  assign w_hs    = wready_q & s_axi_wvalid;
  assign ar_hs   = arready_q & s_axi_arvalid;
  assign wr_ctrl = w_hs && (waddr_q == AddrCtrl) && s_axi_wstrb[0];
  assign rd_ctrl = ar_hs && (s_axi_araddr == AddrCtrl);

  // Write channel FSM: handshake outputs are registered alongside the state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state_q <= WrIdle;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      waddr_q    <= '0;
    end else begin
      case (wr_state_q)
        WrIdle: if (s_axi_awvalid) begin
          waddr_q    <= s_axi_awaddr;
          wr_state_q <= WrData;
          awready_q  <= 1'b0;
          wready_q   <= 1'b1;
        end
        WrData: if (s_axi_wvalid) begin
          wr_state_q <= WrResp;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b1;
        end
        WrResp: if (s_axi_bready) begin
          wr_state_q <= WrIdle;
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
        end
        default: begin
          wr_state_q <= WrIdle;
          awready_q  <= 1'b1;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM: rdata is captured on the AR handshake and held until rready.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_state_q <= RdIdle;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RdIdle: if (s_axi_arvalid) begin
          rdata_q    <= rd_mux;
          rd_state_q <= RdData;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b1;
        end
        RdData: if (s_axi_rready) begin
          rd_state_q <= RdIdle;
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b1;
        end
        default: begin
          rd_state_q <= RdIdle;
          arready_q  <= 1'b1;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wmask = '0;
    for (int i = 0; i < int'(StrbW); i++) begin
      wmask[8*i +: 8] = {8{s_axi_wstrb[i]}};
    end
    wmerge_buf = (buf_q & ~wmask) | (s_axi_wdata & wmask);
    wmerge_res = (res_q & ~wmask) | (s_axi_wdata & wmask);
    wmerge_num = (num_q & ~wmask) | (s_axi_wdata & wmask);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      buf_q          <= '0;
      res_q          <= '0;
      num_q          <= '0;
      wen_q          <= 1'b0;
      start_q        <= 1'b0;
      auto_restart_q <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      if (w_hs && waddr_q == AddrBuf) buf_q <= wmerge_buf;
      if (w_hs && waddr_q == AddrRes) res_q <= wmerge_res;
      if (w_hs && waddr_q == AddrNum) num_q <= wmerge_num;
      if (w_hs && waddr_q == AddrWen && s_axi_wstrb[0]) wen_q <= s_axi_wdata[0];
      if (wr_ctrl) auto_restart_q <= s_axi_wdata[7];
      // A set-write beats a coincident ap_ready clear.
      if (wr_ctrl && s_axi_wdata[0]) begin
        start_q <= 1'b1;
      end else if (ap_ready && !auto_restart_q) begin
        start_q <= 1'b0;
      end
      // Status pulse beats clear-on-read so a coincident event is never lost.
      if (ap_done) begin
        done_q <= 1'b1;
      end else if (rd_ctrl) begin
        done_q <= 1'b0;
      end
      if (ap_ready) begin
        ready_q <= 1'b1;
      end else if (rd_ctrl) begin
        ready_q <= 1'b0;
      end
    end
  end

`ifdef AVG_CTRL_IRQ_EN
  localparam logic [ADDR_W-1:0] AddrGie = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] AddrIer = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] AddrIsr = ADDR_W'('h0C);

  logic       gie_q, gie_d, irq_q;
  logic [1:0] ier_q, isr_q, isr_d, irq_ev;
  logic       wr_low;

  assign wr_low = w_hs && s_axi_wstrb[0];
  assign irq_ev = {ap_ready, ap_done};

  always_comb begin
    gie_d = gie_q;
    isr_d = isr_q;
    if (wr_low && waddr_q == AddrGie) gie_d = s_axi_wdata[0];
    for (int i = 0; i < 2; i++) begin
      if (wr_low && waddr_q == AddrIsr && s_axi_wdata[i]) begin
        isr_d[i] = ~isr_q[i];
      end else if (irq_ev[i] && ier_q[i]) begin
        isr_d[i] = 1'b1;
      end
    end
  end

  // Built from next-state values so the interrupt follows the event by one cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gie_q <= 1'b0;
      ier_q <= '0;
      isr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      gie_q <= gie_d;
      isr_q <= isr_d;
      if (wr_low && waddr_q == AddrIer) ier_q <= s_axi_wdata[1:0];
      irq_q <= gie_d & (|isr_d);
    end
  end

  assign interrupt = irq_q;
`else
  assign interrupt = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr)
      AddrCtrl: rd_mux[7:0] = {auto_restart_q, 3'b000, ready_q, ap_idle, done_q, start_q};
`ifdef AVG_CTRL_IRQ_EN
      AddrGie:  rd_mux[0]   = gie_q;
      AddrIer:  rd_mux[1:0] = ier_q;
      AddrIsr:  rd_mux[1:0] = isr_q;
`endif
      AddrBuf:  rd_mux      = buf_q;
      AddrRes:  rd_mux      = res_q;
      AddrNum:  rd_mux      = num_q;
      AddrWen:  rd_mux[0]   = wen_q;
      AddrCnt:  rd_mux      = avg_count;
      default:  rd_mux      = '0;
    endcase
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign ap_start      = start_q;
  assign buf_addr      = buf_q;
  assign result_addr   = res_q;
  assign num_avgs      = num_q;
  assign write_en      = wen_q;

endmodule
